// File: rtl/booth_multiplier_8x8.sv
// Sequential radix-2 Booth multiplier: signed 8x8 -> signed 16-bit product in 8 steps.
// Define BOOTH_DONE_EN to add a one-cycle 'done' completion pulse output.
module booth_multiplier_8x8 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  mc,
   input  logic [7:0]  mp,
   output logic [15:0] prod,
   output logic        busy
`ifdef BOOTH_DONE_EN
   ,
   output logic        done
`endif
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t      r_state;
   logic [7:0]  r_m;
   logic [7:0]  r_q;
   logic [8:0]  r_a;
   logic        r_q1;
   logic [2:0]  r_cnt;
   logic [15:0] r_prod;
   logic        r_busy;

   logic [8:0]  w_sum;
   logic [8:0]  w_a_next;
   logic [7:0]  w_q_next;
   logic        w_q1_next;
   logic        w_last;

   // A is 9 bits wide so that subtracting mc = -128 cannot overflow
   function automatic logic [8:0] booth_add(input logic [8:0] a,
                                            input logic [7:0] m,
                                            input logic [1:0] pair);
      logic [8:0] m_ext;
      logic [8:0] res;
      m_ext = {m[7], m};
      case (pair)
         2'b01:   res = a + m_ext;
         2'b10:   res = a - m_ext;
         default: res = a;
      endcase
      return res;
   endfunction

   // One Booth step: conditional add/subtract followed by arithmetic right shift
   always_comb begin
      w_sum     = booth_add(r_a, r_m, {r_q[0], r_q1});
      w_a_next  = {w_sum[8], w_sum[8:1]};
      w_q_next  = {w_sum[0], r_q[7:1]};
      w_q1_next = r_q[0];
      w_last    = (r_cnt == 3'd7);
   end

   // Control FSM and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_m     <= 8'h00;
         r_q     <= 8'h00;
         r_a     <= 9'h000;
         r_q1    <= 1'b0;
         r_cnt   <= 3'd0;
         r_prod  <= 16'h0000;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_m     <= mc;
                  r_q     <= mp;
                  r_a     <= 9'h000;
                  r_q1    <= 1'b0;
                  r_cnt   <= 3'd0;
                  r_busy  <= 1'b1;
                  r_state <= ST_RUN;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               r_a  <= w_a_next;
               r_q  <= w_q_next;
               r_q1 <= w_q1_next;
               if (w_last) begin
                  r_prod  <= {w_a_next[7:0], w_q_next};
                  r_busy  <= 1'b0;
                  r_cnt   <= 3'd0;
                  r_state <= ST_IDLE;
               end else begin
                  r_busy  <= 1'b1;
                  r_cnt   <= r_cnt + 3'd1;
                  r_state <= ST_RUN;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_cnt   <= 3'd0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef BOOTH_DONE_EN
   logic r_done;

   // Completion pulse, aligned with the first cycle busy reads low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done <= 1'b0;
      end else begin
         r_done <= (r_state == ST_RUN) && w_last;
      end
   end

   assign done = r_done;
`endif

   assign prod = r_prod;
   assign busy = r_busy;

endmodule

// File: tb/tb_booth_multiplier_8x8.sv
// Directed, table-driven bench for booth_multiplier_8x8 (default build and BOOTH_DONE_EN build).
module tb_booth_multiplier_8x8;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  mc;
   logic [7:0]  mp;
   logic [15:0] prod;
   logic        busy;
`ifdef BOOTH_DONE_EN
   logic        done;
`endif

   int          n_checks;
   int          n_fail;
   logic [15:0] last_exp;

   typedef struct {
      logic [7:0]  mc;
      logic [7:0]  mp;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[12];

   booth_multiplier_8x8 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .mc    (mc),
      .mp    (mp),
      .prod  (prod),
      .busy  (busy)
`ifdef BOOTH_DONE_EN
      ,
      .done  (done)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Called at the first negedge after the launch edge. 'hold' keeps start high
   // for that many extra cycles; 'poke' pulses start with 1x1 at that busy cycle.
   task automatic wait_done(input string name, input logic [15:0] exp,
                            input int hold, input int poke);
      int n;
      n = 0;
      while (busy === 1'b1 && n < 20) begin
         if (n == poke) begin
            start = 1'b1;
            mc    = 8'd1;
            mp    = 8'd1;
         end else begin
            start = (n < hold);
         end
         check({name, "_prod_hold"}, prod, last_exp);
`ifdef BOOTH_DONE_EN
         check({name, "_done_low"}, {15'h0, done}, 16'h0000);
`endif
         n++;
         @(negedge clk);
      end
      start = 1'b0;
      check({name, "_busy_cycles"}, n[15:0], 16'd8);
      check({name, "_prod"}, prod, exp);
      last_exp = exp;
`ifdef BOOTH_DONE_EN
      check({name, "_done_pulse"}, {15'h0, done}, 16'h0001);
`endif
      @(negedge clk);
      check({name, "_idle_after"}, {15'h0, busy}, 16'h0000);
`ifdef BOOTH_DONE_EN
      check({name, "_done_clear"}, {15'h0, done}, 16'h0000);
`endif
   endtask

   task automatic do_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input int hold, input int poke);
      @(negedge clk);
      mc    = a;
      mp    = b;
      start = 1'b1;
      @(negedge clk);
      check({name, "_busy_rise"}, {15'h0, busy}, 16'h0001);
      wait_done(name, exp, hold, poke);
   endtask

   initial begin
      int first_fall;
      int second_fall;
      int cyc;
      logic prev_busy;

      n_checks = 0;
      n_fail   = 0;
      last_exp = 16'h0000;

      vecs[0]  = '{8'd3,   8'd10,  16'h001E};
      vecs[1]  = '{8'hFD,  8'd10,  16'hFFE2};
      vecs[2]  = '{8'h80,  8'h80,  16'h4000};
      vecs[3]  = '{8'd127, 8'h80,  16'hC080};
      vecs[4]  = '{8'h80,  8'd127, 16'hC080};
      vecs[5]  = '{8'd127, 8'd127, 16'h3F01};
      vecs[6]  = '{8'hFF,  8'hFF,  16'h0001};
      vecs[7]  = '{8'd0,   8'hFF,  16'h0000};
      vecs[8]  = '{8'd1,   8'h80,  16'hFF80};
      vecs[9]  = '{8'hF9,  8'd6,   16'hFFD6};
      vecs[10] = '{8'hAA,  8'h55,  16'hE372};
      vecs[11] = '{8'd5,   8'd7,   16'h0023};

      rst_n = 1'b0;
      start = 1'b0;
      mc    = 8'h00;
      mp    = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_busy", {15'h0, busy}, 16'h0000);
      check("reset_prod", prod, 16'h0000);
`ifdef BOOTH_DONE_EN
      check("reset_done", {15'h0, done}, 16'h0000);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      // start held two cycles; must not relaunch after completion
      do_op("start2cyc", 8'd3, 8'd10, 16'h001E, 1, -1);
      @(negedge clk);
      check("start2cyc_no_relaunch", {15'h0, busy}, 16'h0000);

      for (int i = 0; i < 12; i++) begin
         do_op($sformatf("vec%0d", i), vecs[i].mc, vecs[i].mp, vecs[i].exp, 0, -1);
      end

      // start pulsed mid-operation and on the completing edge: both ignored
      do_op("ignore_mid", 8'd5, 8'd7, 16'h0023, 0, 3);
      do_op("ignore_last", 8'hFD, 8'hFD, 16'h0009, 0, 7);

      // asynchronous reset after four steps aborts the operation
      @(negedge clk);
      mc    = 8'd9;
      mp    = 8'd9;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", {15'h0, busy}, 16'h0000);
      check("abort_prod", prod, 16'h0000);
      last_exp = 16'h0000;
      @(negedge clk);
      rst_n = 1'b1;
      do_op("after_reset", 8'd2, 8'd2, 16'h0004, 0, -1);

      // back-to-back with start held high: completions 9 cycles apart
      @(negedge clk);
      mc          = 8'd4;
      mp          = 8'hFB;
      start       = 1'b1;
      first_fall  = -1;
      second_fall = -1;
      prev_busy   = 1'b0;
      cyc         = 0;
      while (second_fall < 0 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (prev_busy && !busy) begin
            check("b2b_prod", prod, 16'hFFEC);
`ifdef BOOTH_DONE_EN
            check("b2b_done", {15'h0, done}, 16'h0001);
`endif
            if (first_fall < 0) first_fall = cyc;
            else second_fall = cyc;
         end
         prev_busy = busy;
      end
      start = 1'b0;
      check("b2b_spacing", 16'(second_fall - first_fall), 16'd9);
      repeat (10) @(negedge clk);
      check("b2b_final_idle", {15'h0, busy}, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
